// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and frame constants, common to the rx and tx blocks.
// Latency: none; this package only holds types, constants and a width helper.
// Backpressure: not applicable; the package holds no logic.
package uart_rx_pkg;

    // One encoding for both directions, so rx and tx state can be compared side by side in waves
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_t;

    // 8N1 framing: 8 data bits, LSB first
    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    // Width of a counter that runs 0..n-1. It never drops below 1 bit, so degenerate baud ratios still elaborate.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer that brings one asynchronous level into the clk domain; reset value is a parameter.
// Latency: 2 clk from d to q.
// Backpressure: none; q follows d continuously.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Resolve metastability over two stages; reset to the line's idle level so no false edge appears
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples the synchronized line with a cycle counter and samples at each bit centre.
// Latency: doneRx pulses 1 clk after the stop-bit centre sample, which comes 3 clk after that point on rx.
// Backpressure: none; doneRx is a 1-clk pulse and rx_data/frame_err hold until the next frame completes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       doneRx,
    output logic       frame_err,
    output logic       busy
);

    localparam int bit_cycles  = clk_freq / baud_rate;
    localparam int half_cycles = bit_cycles / 2;
    localparam int CNT_W       = cnt_width(bit_cycles);

    // Terminal counts. The counter is cleared on each terminal count, so it never wraps.
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(bit_cycles - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_cycles - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 rx_s;

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Frame FSM. It also registers every output, so busy/doneRx/frame_err/rx_data come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            rx_data   <= 8'h00;
            doneRx    <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            doneRx <= 1'b0;
            case (state)
                // Wait for a low level. The level, not just an edge, starts a frame, so a line still low after a bad stop bit is revalidated.
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                // Half a bit in, check that the start bit is still low; a high line here means the low was a glitch
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Now aligned to bit centres: sample once per bit period, LSB first
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt        <= '0;
                        shift[idx] <= rx_s;
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Sample the stop bit, publish the byte and return to IDLE at once so a back-to-back start is not missed
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt       <= '0;
                        rx_data   <= shift;
                        doneRx    <= 1'b1;
                        frame_err <= ~rx_s;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1 frames at nominal and skewed bit periods, glitch, framing error and mid-frame reset.
// Latency: checks rely on doneRx being a 1-clk pulse, with frames 1040 clk apart when sent back to back.
// Backpressure: not applicable; the bench drives rx freely and only observes.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       doneRx;
    logic       frame_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state: one entry per doneRx pulse
    logic [7:0] pulse_data[$];
    logic       pulse_ferr[$];
    int         pulse_cyc[$];
    int         cyc = 0;
    int         n_wide = 0;
    logic       prev_done = 1'b0;

    uart_rx #(
        .clk_freq  (1000000),
        .baud_rate (9600)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .doneRx    (doneRx),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every doneRx pulse on the falling edge and flag any pulse that lasts longer than 1 clk
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (doneRx === 1'b1) begin
            if (prev_done === 1'b1) begin
                n_wide = n_wide + 1;
            end else begin
                pulse_data.push_back(rx_data);
                pulse_ferr.push_back(frame_err);
                pulse_cyc.push_back(cyc);
            end
        end
        prev_done = doneRx;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Hold rx at v for period clocks; the caller is always 1 time unit after a rising edge
    task automatic drive_bit(input logic v, input int period);
        rx = v;
        repeat (period) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int period);
        drive_bit(1'b0, period);
        for (int i = 0; i < 8; i++) drive_bit(b[i], period);
        drive_bit(stop, period);
    endtask

    int exp_pulses;
    int base;
    int gap;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rx_data",   rx_data,   8'h00);
        check_eq("rst_doneRx",    doneRx,    1'b0);
        check_eq("rst_frame_err", frame_err, 1'b0);
        check_eq("rst_busy",      busy,      1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bit(1'b1, 20);
        exp_pulses = 0;

        // Nominal frame 0xA5
        send_byte(8'hA5, 1'b1, 104);
        drive_bit(1'b1, 20);
        exp_pulses = exp_pulses + 1;
        check_eq("a5_pulses",    pulse_data.size(), exp_pulses);
        check_eq("a5_rx_data",   rx_data,   8'hA5);
        check_eq("a5_frame_err", frame_err, 1'b0);
        check_eq("a5_busy_idle", busy,      1'b0);

        // 20-clk low glitch: busy while the start bit is checked, then back to IDLE with nothing delivered
        drive_bit(1'b0, 10);
        check_eq("glitch_busy_mid", busy, 1'b1);
        drive_bit(1'b0, 10);
        drive_bit(1'b1, 200);
        check_eq("glitch_pulses",  pulse_data.size(), exp_pulses);
        check_eq("glitch_rx_data", rx_data, 8'hA5);
        check_eq("glitch_busy",    busy,    1'b0);

        // Stop bit low -> framing error, byte still delivered; a good frame afterwards clears the error
        send_byte(8'h3C, 1'b0, 104);
        drive_bit(1'b1, 300);
        exp_pulses = exp_pulses + 1;
        check_eq("ferr_pulses",    pulse_data.size(), exp_pulses);
        check_eq("ferr_rx_data",   rx_data,   8'h3C);
        check_eq("ferr_frame_err", frame_err, 1'b1);
        send_byte(8'h01, 1'b1, 104);
        drive_bit(1'b1, 100);
        exp_pulses = exp_pulses + 1;
        check_eq("ok01_pulses",    pulse_data.size(), exp_pulses);
        check_eq("ok01_rx_data",   rx_data,   8'h01);
        check_eq("ok01_frame_err", frame_err, 1'b0);

        // Back-to-back 0x00 then 0xFF with no idle gap
        base = pulse_data.size();
        send_byte(8'h00, 1'b1, 104);
        send_byte(8'hFF, 1'b1, 104);
        drive_bit(1'b1, 100);
        exp_pulses = exp_pulses + 2;
        check_eq("b2b_pulses", pulse_data.size(), exp_pulses);
        if (pulse_data.size() >= base + 2) begin
            check_eq("b2b_first",  pulse_data[base],     8'h00);
            check_eq("b2b_second", pulse_data[base + 1], 8'hFF);
            gap = pulse_cyc[base + 1] - pulse_cyc[base];
            check_eq("b2b_gap_1040pm2", (gap >= 1038 && gap <= 1042), 1'b1);
        end

        // Reset during data bit 4 of 0xF0. Bits 4..7 and the stop bit are high, so no false start follows.
        drive_bit(1'b0, 104);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, 104);
        drive_bit(1'b1, 50);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_rx_data",   rx_data,   8'h00);
        check_eq("midrst_doneRx",    doneRx,    1'b0);
        check_eq("midrst_frame_err", frame_err, 1'b0);
        check_eq("midrst_busy",      busy,      1'b0);
        @(posedge clk);
        #1;
        drive_bit(1'b1, 54 + 4 * 104 + 300);
        check_eq("midrst_pulses", pulse_data.size(), exp_pulses);
        send_byte(8'h5A, 1'b1, 104);
        drive_bit(1'b1, 100);
        exp_pulses = exp_pulses + 1;
        check_eq("post_rst_pulses",    pulse_data.size(), exp_pulses);
        check_eq("post_rst_rx_data",   rx_data,   8'h5A);
        check_eq("post_rst_frame_err", frame_err, 1'b0);

        // +/-3% bit period skew
        send_byte(8'h96, 1'b1, 101);
        drive_bit(1'b1, 300);
        exp_pulses = exp_pulses + 1;
        check_eq("fast_pulses",    pulse_data.size(), exp_pulses);
        check_eq("fast_rx_data",   rx_data,   8'h96);
        check_eq("fast_frame_err", frame_err, 1'b0);
        send_byte(8'h96, 1'b1, 107);
        drive_bit(1'b1, 300);
        exp_pulses = exp_pulses + 1;
        check_eq("slow_pulses",    pulse_data.size(), exp_pulses);
        check_eq("slow_rx_data",   rx_data,   8'h96);
        check_eq("slow_frame_err", frame_err, 1'b0);

        check_eq("done_pulse_width", n_wide, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter clk_freq, default 1000000, system clock frequency in Hz.
REQ-002 Parameter baud_rate, default 9600, line bit rate in baud.
REQ-003 clk  input  1  system clock; the only clock, all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 rx_data  output  8  last received byte, valid while doneRx is high and held until the next frame completes.
REQ-007 doneRx  output  1  one-clk pulse marking frame completion.
REQ-008 frame_err  output  1  set together with doneRx when the stop bit sampled low, else 0.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 Local constant bit_cycles = clk_freq/baud_rate (integer division; 104 at defaults); half_cycles = bit_cycles/2 (52).
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rx_s (2 clk latency).
REQ-012 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-013 State machine SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE: cycle counter and bit index held at 0; on rx_s = 0, go to START with the counter cleared.
REQ-015 START: count to half_cycles-1, then sample rx_s. If rx_s = 0, go to DATA with the counter cleared. If rx_s = 1 (glitch), return to IDLE with no output change.
REQ-016 DATA: count to bit_cycles-1, then sample rx_s into shift bit [index] and increment the index. After index 7 is sampled, go to STOP.
REQ-017 STOP: count to bit_cycles-1, then sample rx_s. On the following clk, load rx_data from the shift register, pulse doneRx for exactly 1 clk, set frame_err = ~rx_s, and return to IDLE.
REQ-018 Timing: doneRx rises 1 clk after the stop-bit mid-point sample; each sample point is nominally at the bit centre.
REQ-019 frame_err SHALL remain valid until the next doneRx or reset.
REQ-020 Back-to-back frames: a start edge arriving on the first IDLE cycle after STOP SHALL be accepted with no lost frame.
REQ-021 A frame_err frame SHALL still deliver rx_data. The receiver SHALL NOT wait for the line to return high; if rx_s is still 0 in IDLE, it is treated as a new start and revalidated by REQ-015.
REQ-022 Counters SHALL be sized from bit_cycles via a clog2-based width and SHALL never wrap during normal operation.
REQ-023 Unused state encodings SHALL transition to IDLE on the next clk.

Reset
REQ-024 While rst = 1 at a clk edge: state = IDLE, counters = 0, shift register = 0, rx_data = 8'h00, doneRx = 0, frame_err = 0, busy = 0, synchronizer flops = 1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no doneRx pulse. Reception resumes on the first falling edge of rx_s after rst deasserts.

Structure
REQ-026 A shared package SHALL hold the state encodings (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and the frame constant DATA_BITS = 8. The uarttx block and this block share the encodings.
REQ-027 One sub-module, sync2 (2-flop synchronizer, parameterized reset value), SHALL be instantiated for rx. All other logic stays in uart_rx.
REQ-028 Target size is 120-250 lines of RTL with no derived or gated clocks.

Verification
REQ-029 Send 0xA5 at 104 clk/bit with stop = 1 -> rx_data = 8'hA5, doneRx high for exactly 1 clk, frame_err = 0, busy low after the pulse.
REQ-030 Drive rx low for 20 clk, then high -> return to IDLE, no doneRx, rx_data unchanged.
REQ-031 Send 0x3C with stop bit = 0 -> doneRx pulse, rx_data = 8'h3C, frame_err = 1. A following valid 0x01 -> frame_err = 0.
REQ-032 Send 0x00 and 0xFF back-to-back with no idle gap -> two doneRx pulses carrying 8'h00 then 8'hFF, 1040 +/- 2 clk apart.
REQ-033 Assert rst for 1 clk during data bit 4 of a frame -> no doneRx and all outputs at reset values. A subsequent 0x5A frame is received correctly.
REQ-034 Send 0x96 with the bit period skewed +/-3% (101 and 107 clk/bit) -> rx_data = 8'h96 and frame_err = 0 in both cases.
